uim_switchbox: RTL

Parametrised universal interconnect multiplexer (UIM) for the CPLD model. It routes any of `N_SRC` source signals (pad inputs plus macrocell feedback) onto each of `N_UIM` logic-block inputs. Routing is set by a serially loaded, double-buffered configuration. A shadow chain is filled through a start/shift/commit sequence and then copied atomically to the active map. One instance sits in front of each logic block in the device top.

---
 rtl/uim_switchbox_if.sv | 30 +++
 rtl/uim_switchbox.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uim_switchbox_if.sv
// rtl/uim_switchbox_if.sv - serial configuration port of the UIM switchbox
//
// cfg_start  : begin a new load, clears the bit counter and the error flag
// cfg_valid  : shift cfg_sdi into the shadow chain this cycle
// cfg_sdi    : serial configuration data
// cfg_commit : copy shadow map to active map
// cfg_sdo    : shadow bit 0 (readback / daisy chain)
// cfg_busy   : high while a load is shifting
// cfg_done   : one-cycle pulse after a successful commit
// cfg_err    : sticky protocol error
interface uim_switchbox_if;
    logic cfg_start;
    logic cfg_valid;
    logic cfg_sdi;
    logic cfg_commit;
    logic cfg_sdo;
    logic cfg_busy;
    logic cfg_done;
    logic cfg_err;

    modport master (
        output cfg_start, cfg_valid, cfg_sdi, cfg_commit,
        input  cfg_sdo, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_sdi, cfg_commit,
        output cfg_sdo, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/uim_switchbox.sv
// rtl/uim_switchbox.sv - universal interconnect multiplexer with double-buffered serial config
//
// clk   : rising-edge clock
// rst_n : synchronous active-low reset
// src   : N_SRC routable sources (pads + macrocell feedback)
// uim   : N_UIM routed logic-block inputs
// cfg   : serial configuration port (uim_switchbox_if.slave)
module uim_switchbox #(
    parameter int N_SRC        = 64,
    parameter int N_UIM        = 40,
    parameter int SEL_W        = 6,
    parameter bit IDLE_VAL     = 1'b1,
    parameter bit REGISTER_OUT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   src,
    output logic [N_UIM-1:0]   uim,
    uim_switchbox_if.slave     cfg
);

    localparam int E        = SEL_W + 1;
    localparam int CFG_BITS = N_UIM * E;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    count;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                start_load;
    logic                do_shift;
    logic                do_commit;
    logic                set_err;

    logic [N_UIM-1:0]    uim_c;

    // cfg_start overrides everything else in the same cycle: a coincident
    // bit is dropped and a coincident commit is discarded without error.
    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        set_err    = 1'b0;
        if (cfg.cfg_start) begin
            state_nxt  = ST_SHIFT;
            start_load = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // valid is ignored here so a chain can pass through
                    set_err = cfg.cfg_commit;
                end
                ST_SHIFT: begin
                    // a commit on the last shift still sees SHIFT
                    set_err = cfg.cfg_commit;
                    if (cfg.cfg_valid) begin
                        do_shift = 1'b1;
                        if (count == CNT_W'(CFG_BITS - 1)) begin
                            state_nxt = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    set_err = cfg.cfg_valid;
                    if (cfg.cfg_commit) begin
                        do_commit = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            shadow <= '0;
            active <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == ST_SHIFT);
            done_q <= do_commit;
            if (start_load) begin
                count <= '0;
            end else if (do_shift) begin
                count <= count + CNT_W'(1);
            end
            // first bit in reaches shadow[0] after CFG_BITS shifts
            if (do_shift) begin
                shadow <= {cfg.cfg_sdi, shadow[CFG_BITS-1:1]};
            end
            if (do_commit) begin
                active <= shadow;
            end
            if (start_load) begin
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cfg.cfg_sdo  = shadow[0];
    assign cfg.cfg_busy = busy_q;
    assign cfg.cfg_done = done_q;
    assign cfg.cfg_err  = err_q;

    // Selects beyond N_SRC are possible when 2**SEL_W > N_SRC; they read idle.
    for (genvar i = 0; i < N_UIM; i++) begin : g_route
        logic [SEL_W-1:0] sel;
        logic             en;
        assign sel      = active[i*E +: SEL_W];
        assign en       = active[i*E + SEL_W];
        assign uim_c[i] = (en && (int'(sel) < N_SRC)) ? src[sel] : IDLE_VAL;
    end

    if (REGISTER_OUT) begin : g_reg_out
        logic [N_UIM-1:0] uim_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                uim_q <= {N_UIM{IDLE_VAL}};
            end else begin
                uim_q <= uim_c;
            end
        end
        assign uim = uim_q;
    end else begin : g_comb_out
        assign uim = uim_c;
    end

endmodule
